// File: rtl/i2s_udp_packer.sv
// Frames tlast-delimited audio byte blocks into packets with a 4-byte header
// (magic, source indices, 16-bit sequence) and a payload length cap.
module i2s_udp_packer #(
  parameter int          MAX_PAYLOAD = 1024,
  parameter logic [7:0]  MAGIC       = 8'hEA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  fpga_index,
  input  logic [3:0]  i2s_index,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [31:0] pkt_count,
  output logic [15:0] trunc_count
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] seq_q, seq_d;
  logic        tvalid_q, tvalid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [15:0] trunc_count_q, trunc_count_d;
  logic        load;
  logic        s_ready;
  logic        pkt_done;

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    idx_d         = idx_q;
    seq_d         = seq_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    pkt_count_d   = pkt_count_q;
    trunc_count_d = trunc_count_q;
    s_ready       = 1'b0;

    load     = !tvalid_q || m_axis_tready;
    pkt_done = tvalid_q && m_axis_tready && tlast_q;

    // Packet bookkeeping happens when the sink takes the tlast beat.
    if (pkt_done) begin
      pkt_count_d = pkt_count_q + 32'd1;
      seq_d       = seq_q + 16'd1;
      if (tuser_q && (trunc_count_q != 16'hFFFF)) begin
        trunc_count_d = trunc_count_q + 16'd1;
      end
    end

    // A free output slot empties unless a state below fills it.
    if (load) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          if (enable) begin
            state_d   = HDR;
            hdr_cnt_d = 2'd0;
            idx_d     = {fpga_index, i2s_index};
          end else begin
            state_d = DROP;
          end
        end
      end
      HDR: begin
        if (load) begin
          tvalid_d  = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          unique case (hdr_cnt_q)
            2'd0:    tdata_d = MAGIC;
            2'd1:    tdata_d = idx_q;
            2'd2:    tdata_d = seq_q[15:8];
            default: tdata_d = seq_q[7:0];
          endcase
          if (hdr_cnt_q == 2'd3) begin
            state_d   = PAYLOAD;
            pay_cnt_d = 16'd0;
          end
        end
      end
      PAYLOAD: begin
        s_ready = load;
        if (s_axis_tvalid && load) begin
          tvalid_d  = 1'b1;
          tdata_d   = s_axis_tdata;
          pay_cnt_d = pay_cnt_q + 16'd1;
          // Input tlast wins over the cap, so a block of exactly the cap length ends normally.
          if (s_axis_tlast) begin
            tlast_d = 1'b1;
            state_d = IDLE;
          end else if (({1'b0, pay_cnt_q} + 17'd1) == MAX_LEN) begin
            tlast_d = 1'b1;
            tuser_d = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hdr_cnt_q     <= 2'd0;
      pay_cnt_q     <= 16'd0;
      idx_q         <= 8'd0;
      seq_q         <= 16'd0;
      tvalid_q      <= 1'b0;
      tdata_q       <= 8'd0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      pkt_count_q   <= 32'd0;
      trunc_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      idx_q         <= idx_d;
      seq_q         <= seq_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      pkt_count_q   <= pkt_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign pkt_count     = pkt_count_q;
  assign trunc_count   = trunc_count_q;

endmodule
